// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, the "no register" id, the fetch FSM
// state type and the ifun legality rule.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StByte0,
        StRegs,
        StConst,
        StFin
    } fetch_state_e;

    // rrmovq doubles as cmovXX, so it shares the jXX condition range.
    function automatic logic ifun_ok(input logic [3:0] icode, input logic [3:0] ifun);
        case (icode)
            IRRMOVQ, IJXX: return ifun <= 4'd6;
            IOPQ:          return ifun <= 4'd3;
            default:       return ifun == 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_need_decode.sv
// Instruction-length decode: which icodes carry a register byte and/or an 8-byte
// constant, and whether the icode exists at all.
module fetch_need_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic       o_need_regids,
    output logic       o_need_valc,
    output logic       o_icode_ok
);

    always_comb begin
        o_need_regids = 1'b0;
        o_need_valc   = 1'b0;
        o_icode_ok    = (i_icode <= IPOPQ);
        case (i_icode)
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: o_need_regids = 1'b1;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                o_need_regids = 1'b1;
                o_need_valc   = 1'b1;
            end
            IJXX, ICALL: o_need_valc = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_byte_fetch.sv
// Byte-serial Y86-64 fetch: walks the instruction one byte per acked request and
// assembles icode/ifun/rA/rB/valC/valP for decode.
module instr_byte_fetch
    import y86_pkg::*;
#(
    parameter bit CHECK_IFUN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] pc_in,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    output logic        busy,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [63:0] r_addr;
    logic [2:0]  r_k;
    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic        r_valid;
    logic        r_ierr;

    logic        w_req;
    logic        w_ok;
    logic        w_err;
    logic [3:0]  w_dec_icode;
    logic [3:0]  w_dec_ifun;
    logic        w_need_regids;
    logic        w_need_valc;
    logic        w_icode_ok;
    logic        w_legal;

    assign w_ok  = w_req & mem_ack & ~mem_err;
    assign w_err = w_req & mem_ack & mem_err;

    // In BYTE0 the opcode is still on the bus; afterwards it comes from the register.
    assign w_dec_icode = (r_state == StByte0) ? mem_rdata[7:4] : r_icode;
    assign w_dec_ifun  = (r_state == StByte0) ? mem_rdata[3:0] : r_ifun;

    fetch_need_decode u_need_decode (
        .i_icode       (w_dec_icode),
        .o_need_regids (w_need_regids),
        .o_need_valc   (w_need_valc),
        .o_icode_ok    (w_icode_ok)
    );

    assign w_legal = w_icode_ok && (!CHECK_IFUN || ifun_ok(w_dec_icode, w_dec_ifun));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (start) w_state_next = StByte0;
            end
            StByte0: begin
                if (w_err) begin
                    w_state_next = StFin;
                end else if (w_ok) begin
                    if (!w_icode_ok)        w_state_next = StFin;
                    else if (w_need_regids) w_state_next = StRegs;
                    else if (w_need_valc)   w_state_next = StConst;
                    else                    w_state_next = StFin;
                end
            end
            StRegs: begin
                if (w_err)     w_state_next = StFin;
                else if (w_ok) w_state_next = w_need_valc ? StConst : StFin;
            end
            StConst: begin
                if (w_err || (w_ok && r_k == 3'd7)) w_state_next = StFin;
            end
            StFin:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            StByte0, StRegs, StConst: begin
                w_req = 1'b1;
                busy  = 1'b1;
            end
            StFin:   done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_k     <= '0;
            r_icode <= '0;
            r_ifun  <= '0;
            r_ra    <= RNONE;
            r_rb    <= RNONE;
            r_valc  <= '0;
            r_valp  <= '0;
            r_valid <= 1'b0;
            r_ierr  <= 1'b0;
        end else begin
            if (r_state == StIdle && start) begin
                r_addr  <= pc_in;
                r_k     <= '0;
                r_icode <= '0;
                r_ifun  <= '0;
                r_ra    <= RNONE;
                r_rb    <= RNONE;
                r_valc  <= '0;
                r_valp  <= '0;
                r_valid <= 1'b0;
                r_ierr  <= 1'b0;
            end
            if (w_ok) begin
                r_addr <= r_addr + 64'd1;
                case (r_state)
                    StByte0: begin
                        r_icode <= mem_rdata[7:4];
                        r_ifun  <= mem_rdata[3:0];
                    end
                    StRegs: begin
                        r_ra <= mem_rdata[7:4];
                        r_rb <= mem_rdata[3:0];
                    end
                    StConst: begin
                        r_valc[{r_k, 3'b000} +: 8] <= mem_rdata;
                        r_k                        <= r_k + 3'd1;
                    end
                    default: ;
                endcase
                if (w_state_next == StFin) begin
                    r_valp  <= r_addr + 64'd1;
                    r_valid <= w_legal;
                end
            end
            // The erroring byte is not consumed: valP points at it.
            if (w_err) begin
                r_ierr  <= 1'b1;
                r_valid <= 1'b0;
                r_valp  <= r_addr;
            end
        end
    end

    assign mem_req     = w_req;
    assign mem_addr    = r_addr;
    assign icode       = r_icode;
    assign ifun        = r_ifun;
    assign rA          = r_ra;
    assign rB          = r_rb;
    assign valC        = r_valc;
    assign valP        = r_valp;
    assign instr_valid = r_valid;
    assign imem_error  = r_ierr;

endmodule

// File: tb/tb_instr_byte_fetch.sv
// Self-checking bench for instr_byte_fetch: directed vector table, hand-written
// multi-cycle sequences and randomized fetches against a byte-walking reference model.
module tb_instr_byte_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] pc_in = '0;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        busy;
    logic        done;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;

    instr_byte_fetch #(
        .CHECK_IFUN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .busy        (busy),
        .done        (done),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .instr_valid (instr_valid),
        .imem_error  (imem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        valid;
        logic        ierr;
        int          n_reads;
    } res_t;

    typedef struct {
        logic [63:0]      pc;
        logic [0:9][7:0]  b;
        int               err_idx;
        res_t             e;
        int               lat;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          stab_viol = 0;
    int          ack_mode = 0;  // 0: tied high, 1: ack every third cycle, 2: random
    int          wait_cnt = 0;
    bit          err_en = 1'b0;
    logic [63:0] err_addr = '0;
    logic [63:0] reads[$];
    bit          prev_pend = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [7:0]  mem [logic [63:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    // Memory responder and bus monitor.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (prev_pend && mem_req && mem_addr != prev_addr) stab_viol++;
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: begin
                if (mem_req) begin
                    if (wait_cnt == 2) begin
                        mem_ack  = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        mem_ack = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt = 0;
                end
            end
            default: mem_ack = ($urandom_range(0, 2) != 0);
        endcase
        mem_rdata = mem_rd(mem_addr);
        if (mem_req) mem_err = err_en && (mem_addr == err_addr);
        else         mem_err = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (mem_req && mem_ack) reads.push_back(mem_addr);
        prev_pend = mem_req && !mem_ack;
        prev_addr = mem_addr;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 1;
        endcase
    endfunction

    function automatic logic [3:0] max_ifun(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h7: return 4'd6;
            4'h6:       return 4'd3;
            default:    return 4'd0;
        endcase
    endfunction

    // Reference: read the instruction byte by byte from the memory image.
    function automatic void model(input logic [63:0] pc, output res_t r);
        int         len;
        bit         regs;
        logic [63:0] a;
        logic [7:0] b;
        r = '{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0, 0};
        len  = 1;
        regs = 1'b0;
        for (int i = 0; i < len; i++) begin
            a = pc + 64'(i);
            r.n_reads = i + 1;
            if (err_en && a == err_addr) begin
                r.ierr = 1'b1;
                r.valp = a;
                return;
            end
            b = mem_rd(a);
            if (i == 0) begin
                r.icode = b[7:4];
                r.ifun  = b[3:0];
                len     = ilen(b[7:4]);
                regs    = (len == 2 || len == 10);
            end else if (i == 1 && regs) begin
                r.ra = b[7:4];
                r.rb = b[3:0];
            end else begin
                r.valc[8 * (i - (regs ? 2 : 1)) +: 8] = b;
            end
        end
        r.valp  = pc + 64'(len);
        r.valid = (r.icode <= 4'hB) && (r.ifun <= max_ifun(r.icode));
    endfunction

    task automatic cmp_res(input string t, input res_t e);
        chk({t, ".icode"}, 64'(icode), 64'(e.icode));
        chk({t, ".ifun"}, 64'(ifun), 64'(e.ifun));
        chk({t, ".rA"}, 64'(rA), 64'(e.ra));
        chk({t, ".rB"}, 64'(rB), 64'(e.rb));
        chk({t, ".valC"}, valC, e.valc);
        chk({t, ".valP"}, valP, e.valp);
        chk({t, ".instr_valid"}, 64'(instr_valid), 64'(e.valid));
        chk({t, ".imem_error"}, 64'(imem_error), 64'(e.ierr));
    endtask

    task automatic check_reads(input string t, input logic [63:0] pc, input int n);
        int bad = 0;
        chk({t, ".nreads"}, 64'(reads.size()), 64'(n));
        foreach (reads[i]) if (reads[i] != pc + 64'(i)) bad++;
        chk({t, ".read_addr"}, 64'(bad), 64'h0);
    endtask

    task automatic chk_reset(input string t);
        chk({t, ".mem_req"}, 64'(mem_req), 64'h0);
        chk({t, ".mem_addr"}, mem_addr, 64'h0);
        chk({t, ".busy"}, 64'(busy), 64'h0);
        chk({t, ".done"}, 64'(done), 64'h0);
        cmp_res(t, '{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0, 0});
    endtask

    // Called at the negedge where start was dropped; returns at the done negedge.
    task automatic wait_done(input string t, input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                lat = cyc - c0;
                break;
            end
            @(negedge clk);
        end
        chk({t, ".timeout"}, 64'(lat < 0), 64'h0);
    endtask

    task automatic run_fetch(input string t, input logic [63:0] pc, output int lat);
        int c0;
        reads.delete();
        @(negedge clk);
        pc_in = pc;
        start = 1'b1;
        c0    = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_done(t, c0, lat);
        @(negedge clk);
        chk({t, ".done_width"}, 64'(done), 64'h0);
    endtask

    task automatic load(input logic [63:0] pc, input logic [0:9][7:0] b);
        mem.delete();
        for (int i = 0; i < 10; i++) mem[pc + 64'(i)] = b[i];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        vecs[12];
    res_t        e;
    int          lat;
    int          c0;
    int          d0;
    logic [63:0] pc;
    logic [0:9][7:0] bytes;

    initial begin
        vecs[0]  = '{64'h100, 80'h10_00_00_00_00_00_00_00_00_00, -1,
                     '{4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101, 1'b1, 1'b0, 1}, 2};
        vecs[1]  = '{64'h200, 80'h30_F3_EF_CD_AB_89_67_45_23_01, -1,
                     '{4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h20A, 1'b1, 1'b0, 10}, 11};
        vecs[2]  = '{64'h500, 80'hC0_11_22_33_44_55_66_77_88_99, -1,
                     '{4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h501, 1'b0, 1'b0, 1}, 2};
        vecs[3]  = '{64'h300, 80'h20_12_00_00_00_00_00_00_00_00, 1,
                     '{4'h2, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301, 1'b0, 1'b1, 2}, 3};
        vecs[4]  = '{64'h0, 80'h00_00_00_00_00_00_00_00_00_00, -1,
                     '{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 1'b1, 1'b0, 1}, 2};
        vecs[5]  = '{64'h700, 80'h64_01_00_00_00_00_00_00_00_00, -1,
                     '{4'h6, 4'h4, 4'h0, 4'h1, 64'h0, 64'h702, 1'b0, 1'b0, 2}, 3};
        vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFE, 80'h50_12_11_22_33_44_55_66_77_88, -1,
                     '{4'h5, 4'h0, 4'h1, 4'h2, 64'h8877665544332211, 64'h8, 1'b1, 1'b0, 10}, 11};
        vecs[7]  = '{64'h800, 80'h21_45_00_00_00_00_00_00_00_00, -1,
                     '{4'h2, 4'h1, 4'h4, 4'h5, 64'h0, 64'h802, 1'b1, 1'b0, 2}, 3};
        vecs[8]  = '{64'h900, 80'h77_01_02_03_04_05_06_07_08_00, -1,
                     '{4'h7, 4'h7, 4'hF, 4'hF, 64'h0807060504030201, 64'h909, 1'b0, 1'b0, 9}, 10};
        vecs[9]  = '{64'hA00, 80'h80_11_22_33_44_55_66_77_88_99, 4,
                     '{4'h8, 4'h0, 4'hF, 4'hF, 64'h332211, 64'hA04, 1'b0, 1'b1, 5}, 6};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h90_00_00_00_00_00_00_00_00_00, -1,
                     '{4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0, 1}, 2};
        vecs[11] = '{64'hB00, 80'hA0_2F_00_00_00_00_00_00_00_00, -1,
                     '{4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 64'hB02, 1'b1, 1'b0, 2}, 3};

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // Directed vectors, ack tied high.
        ack_mode = 0;
        foreach (vecs[v]) begin
            load(vecs[v].pc, vecs[v].b);
            err_en   = (vecs[v].err_idx >= 0);
            err_addr = vecs[v].pc + 64'(vecs[v].err_idx);
            run_fetch($sformatf("vec%0d", v), vecs[v].pc, lat);
            cmp_res($sformatf("vec%0d", v), vecs[v].e);
            chk($sformatf("vec%0d.latency", v), 64'(lat), 64'(vecs[v].lat));
            check_reads($sformatf("vec%0d", v), vecs[v].pc, vecs[v].e.n_reads);
        end
        err_en = 1'b0;

        // jXX with every ack delayed two cycles: nine reads, three cycles each.
        ack_mode = 1;
        load(64'h40, 80'h73_A1_B2_C3_D4_E5_F6_07_18_00);
        run_fetch("slow_jxx", 64'h40, lat);
        cmp_res("slow_jxx", '{4'h7, 4'h3, 4'hF, 4'hF, 64'h1807F6E5D4C3B2A1, 64'h49, 1'b1, 1'b0, 9});
        chk("slow_jxx.latency", 64'(lat), 64'd28);
        check_reads("slow_jxx", 64'h40, 9);
        ack_mode = 0;

        // Reset while the call's constant byte k=4 (address 0x605) is being acked.
        load(64'h600, 80'h80_01_02_03_04_05_06_07_08_00);
        @(negedge clk);
        pc_in = 64'h600;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst.busy_before", 64'(busy), 64'h1);
        chk("midrst.addr_before", mem_addr, 64'h605);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midrst");
        repeat (20) @(negedge clk);
        chk("midrst.no_done", 64'(done_cnt), 64'(d0));
        run_fetch("after_rst", 64'h600, lat);
        model(64'h600, e);
        cmp_res("after_rst", e);
        chk("after_rst.latency", 64'(lat), 64'd10);
        check_reads("after_rst", 64'h600, 9);

        // Starts while busy and on the done cycle are both ignored.
        load(64'h200, 80'h30_F3_EF_CD_AB_89_67_45_23_01);
        mem[64'h100] = 8'h10;
        reads.delete();
        @(negedge clk);
        pc_in = 64'h200;
        start = 1'b1;
        c0    = cyc;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        pc_in = 64'h100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", c0, lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start.latency", 64'(lat), 64'd11);
        chk("done_start.busy", 64'(busy), 64'h0);
        chk("done_start.mem_req", 64'(mem_req), 64'h0);
        cmp_res("busy_start", '{4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h20A,
                                1'b1, 1'b0, 10});
        check_reads("busy_start", 64'h200, 10);

        // Randomized fetches against the reference model.
        for (int it = 0; it < 60; it++) begin
            pc = {32'($urandom), 32'($urandom)};
            if (it % 8 == 0) pc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
            if ($urandom_range(0, 3) != 0) bytes[0][7:4] = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 2) != 0) bytes[0][3:0] = 4'($urandom_range(0, 3));
            load(pc, bytes);
            err_en   = ($urandom_range(0, 3) == 0);
            err_addr = pc + 64'($urandom_range(0, 9));
            ack_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            run_fetch($sformatf("rnd%0d", it), pc, lat);
            model(pc, e);
            cmp_res($sformatf("rnd%0d", it), e);
            check_reads($sformatf("rnd%0d", it), pc, e.n_reads);
            if (ack_mode == 0)
                chk($sformatf("rnd%0d.latency", it), 64'(lat), 64'(e.n_reads + 1));
        end
        ack_mode = 0;
        err_en   = 1'b0;

        chk("mem_addr_stable", 64'(stab_viol), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
